// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-memory fetch controller.
package imem_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } fetch_state_e;

  localparam logic [15:0] NopInstr = 16'h0000;

  // Byte address -> 16-bit word index.
  localparam int unsigned ByteShift = 1;

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W instruction storage: async clear to NOP, synchronous write, registered read.
module imem_array
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AW     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= DATA_W'(NopInstr);
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read samples pre-edge contents, so a same-edge write is not visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= DATA_W'(NopInstr);
    end else if (rd_en) begin
      rd_data_q <= rd_clr ? DATA_W'(NopInstr) : mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory with req/valid fetch handshake, programmable wait states and a load port.
// Optional macro IMEM_BOUNDS_CHECK_EN: out-of-range fetches return NOP with fetch_err.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
`ifdef IMEM_BOUNDS_CHECK_EN
  output logic              fetch_err,
`endif
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int unsigned IdxW = ADDR_W - ByteShift;
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_state_e    state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] req_idx, rd_idx, wr_idx;
  logic [AW-1:0]   rd_word, wr_word;
  logic            rd_en, rd_clr, wr_ok;

  assign req_idx = fetch_addr[ADDR_W-1:ByteShift];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    fetch_ready = 1'b0;
    instr_valid = 1'b0;
    rd_en       = 1'b0;
    rd_idx      = idx_q;
    unique case (state_q)
      StIdle: begin
        fetch_ready = 1'b1;
        // Zero wait states read on the accept edge, before idx_q holds the index.
        rd_idx      = req_idx;
        if (fetch_req) begin
          idx_d = req_idx;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            rd_en   = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        instr_valid = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign rd_word = AW'(32'(rd_idx) % DEPTH);
  assign wr_idx  = load_addr[ADDR_W-1:ByteShift];
  assign wr_ok   = load_en && (32'(wr_idx) < DEPTH);
  assign wr_word = AW'(wr_idx);

`ifdef IMEM_BOUNDS_CHECK_EN
  logic fetch_err_q;

  assign rd_clr = 32'(rd_idx) >= DEPTH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_err_q <= 1'b0;
    end else if (rd_en) begin
      fetch_err_q <= rd_clr;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign rd_clr = 1'b0;
`endif

  imem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_ok),
    .wr_addr(wr_word),
    .wr_data(load_data),
    .rd_en  (rd_en),
    .rd_clr (rd_clr),
    .rd_addr(rd_word),
    .rd_data(instr_data)
  );

  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[ByteShift-1:0], load_addr[ByteShift-1:0]};

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: three instances with 0, 1 and 3 wait states.
module tb_imem_fetch_ctrl;

  localparam int unsigned DEPTH = 32;
  localparam int          MWS   = 1;
  localparam int          WS_TAB [3] = '{0, 1, 3};

  logic        clk;
  logic        reset;
  logic [2:0]  req_v, rdy_v, vld_v, err_v;
  logic [15:0] addr_v [3];
  logic [15:0] dat_v  [3];
  logic        load_en;
  logic [15:0] load_addr, load_data;

  int checks;
  int failures;
  bit chk_en;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    imem_fetch_ctrl #(
      .DATA_W     (16),
      .DEPTH      (DEPTH),
      .ADDR_W     (16),
      .WAIT_STATES(WS_TAB[g])
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .fetch_req  (req_v[g]),
      .fetch_addr (addr_v[g]),
      .fetch_ready(rdy_v[g]),
      .instr_valid(vld_v[g]),
      .instr_data (dat_v[g]),
`ifdef IMEM_BOUNDS_CHECK_EN
      .fetch_err  (err_v[g]),
`endif
      .load_en    (load_en && (g == 1)),
      .load_addr  (load_addr),
      .load_data  (load_data)
    );
  end

`ifndef IMEM_BOUNDS_CHECK_EN
  assign err_v = 3'b000;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model of the WAIT_STATES=1 instance in cycle arithmetic: an accept in cycle c
  // answers in cycle c+MWS+1 and frees the port at c+MWS+2.
  int          cyc;
  int          ready_cyc;
  int          resp_cyc;
  int unsigned pend_idx;
  logic [15:0] mdl_mem [DEPTH];
  logic [15:0] exp_data;
  logic        exp_err;
  logic        acc_now, cap_now;
  int unsigned cur_idx, cap_idx, ld_idx;

  assign cur_idx = 32'(addr_v[1] >> 1);
  assign ld_idx  = 32'(load_addr >> 1);
  assign acc_now = (cyc >= ready_cyc) && req_v[1];
  assign cap_idx = (acc_now && MWS == 0) ? cur_idx : pend_idx;
  assign cap_now = (acc_now && MWS == 0) || (cyc == resp_cyc - 1);

  function automatic logic [16:0] fetch_result(input int unsigned idx);
`ifdef IMEM_BOUNDS_CHECK_EN
    if (idx >= DEPTH) return {1'b1, 16'h0000};
    return {1'b0, mdl_mem[idx]};
`else
    return {1'b0, mdl_mem[idx % DEPTH]};
`endif
  endfunction

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_cyc <= 0;
      resp_cyc  <= -1;
      pend_idx  <= 0;
      exp_data  <= 16'h0000;
      exp_err   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] <= 16'h0000;
    end else begin
      if (acc_now) begin
        pend_idx  <= cur_idx;
        resp_cyc  <= cyc + MWS + 1;
        ready_cyc <= cyc + MWS + 2;
      end
      if (cap_now) {exp_err, exp_data} <= fetch_result(cap_idx);
      if (load_en && ld_idx < DEPTH) mdl_mem[ld_idx] <= load_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_fetch_ready", 32'(rdy_v[1]), 32'(cyc >= ready_cyc));
      chk("cyc_instr_valid", 32'(vld_v[1]), 32'(cyc == resp_cyc));
      chk("cyc_instr_data", 32'(dat_v[1]), 32'(exp_data));
      if (vld_v[1]) chk("cyc_fetch_err", 32'(err_v[1]), 32'(exp_err));
    end
  end

  task automatic do_load(input logic [15:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Called in an idle cycle at posedge+1; returns in the idle cycle after the response.
  task automatic do_fetch(input int w, input logic [15:0] a, output logic [15:0] d,
                          output int lat, output logic e, output bit rdy_ok);
    d      = 16'h0000;
    e      = 1'b0;
    lat    = -1;
    rdy_ok = 1'b1;
    addr_v[w] = a;
    req_v[w]  = 1'b1;
    @(posedge clk); #1;
    req_v[w] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rdy_v[w]) rdy_ok = 1'b0;
      if (vld_v[w]) begin
        lat = i;
        d   = dat_v[w];
        e   = err_v[w];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (!rdy_v[w]) rdy_ok = 1'b0;
  endtask

  task automatic fetch_chk(input string nm, input int w, input logic [15:0] a,
                           input logic [15:0] exp_d, input int exp_lat);
    logic [15:0] d;
    int          lat;
    logic        e;
    bit          rdy_ok;
    do_fetch(w, a, d, lat, e, rdy_ok);
    chk({nm, "_data"}, 32'(d), 32'(exp_d));
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_ready_low"}, 32'(rdy_ok), 32'd1);
  endtask

  initial begin
    logic [15:0] d;
    int          lat;
    logic        e;
    bit          rdy_ok;
    int          nvalid;
    bit          no_resp;

    checks    = 0;
    failures  = 0;
    chk_en    = 1'b0;
    reset     = 1'b0;
    req_v     = 3'b000;
    load_en   = 1'b0;
    load_addr = 16'h0000;
    load_data = 16'h0000;
    for (int i = 0; i < 3; i++) addr_v[i] = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(rdy_v), 32'h7);
    chk("reset_valid", 32'(vld_v), 32'h0);
    chk("reset_data", 32'(dat_v[1]), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Load then fetch, one wait state.
    do_load(16'h0000, 16'h0120);
    do_load(16'h0002, 16'h0121);
    fetch_chk("ws1_fetch", 1, 16'h0002, 16'h0121, 2);

    // Latency with zero and three wait states.
    fetch_chk("ws0_fetch", 0, 16'h0000, 16'h0000, 1);
    fetch_chk("ws3_fetch", 2, 16'h0000, 16'h0000, 4);

    // Reset in the middle of WAIT drops the fetch and clears memory.
    do_load(16'h0004, 16'h1234);
    addr_v[1] = 16'h0004;
    req_v[1]  = 1'b1;
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    reset    = 1'b0;
    #1;
    chk("midwait_reset_ready", 32'(rdy_v[1]), 32'd1);
    chk("midwait_reset_valid", 32'(vld_v[1]), 32'd0);
    @(posedge clk); #1;
    reset   = 1'b1;
    no_resp = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (vld_v[1]) no_resp = 1'b0;
    end
    chk("dropped_fetch_no_resp", 32'(no_resp), 32'd1);
    @(posedge clk); #1;
    fetch_chk("after_reset_fetch", 1, 16'h0004, 16'h0000, 2);

    // Load on the RESP-entry edge does not affect that read.
    do_load(16'h0006, 16'h0564);
    addr_v[1] = 16'h0006;
    req_v[1]  = 1'b1;
    @(posedge clk); #1;
    req_v[1]  = 1'b0;
    load_en   = 1'b1;
    load_addr = 16'h0006;
    load_data = 16'hEFFF;
    @(posedge clk); #1;
    load_en = 1'b0;
    @(negedge clk);
    chk("same_edge_valid", 32'(vld_v[1]), 32'd1);
    chk("same_edge_old_data", 32'(dat_v[1]), 32'h0564);
    @(posedge clk); #1;
    fetch_chk("same_edge_new_data", 1, 16'h0006, 16'hEFFF, 2);

    // Misaligned fetch reads the even word below.
    do_load(16'h0002, 16'h09E2);
    fetch_chk("misaligned", 1, 16'h0003, 16'h09E2, 2);

    // Out-of-range fetch (idx 33).
    do_load(16'h0002, 16'h0EF2);
    do_fetch(1, 16'h0042, d, lat, e, rdy_ok);
`ifdef IMEM_BOUNDS_CHECK_EN
    chk("oor_data", 32'(d), 32'h0000);
    chk("oor_err", 32'(e), 32'd1);
`else
    chk("oor_wrap_data", 32'(d), 32'h0EF2);
    chk("oor_err", 32'(e), 32'd0);
`endif
    chk("oor_latency", 32'(lat), 32'd2);
    fetch_chk("inrange_after_oor", 1, 16'h0002, 16'h0EF2, 2);
    chk("inrange_err", 32'(err_v[1]), 32'd0);

    // Load beyond DEPTH is ignored; it would otherwise alias word 0.
    do_load(16'h0000, 16'h1111);
    do_load(16'h0040, 16'hBEEF);
    fetch_chk("oor_load_ignored", 1, 16'h0000, 16'h1111, 2);

    // Held request: one fetch every WAIT_STATES+2 cycles.
    addr_v[1] = 16'h0002;
    req_v[1]  = 1'b1;
    nvalid    = 0;
    repeat (9) begin
      @(negedge clk);
      if (vld_v[1]) nvalid++;
      @(posedge clk); #1;
    end
    req_v[1] = 1'b0;
    chk("throughput_9_cycles", 32'(nvalid), 32'd3);
    repeat (4) @(posedge clk);
    #1;

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Parametrised instruction memory with a request/valid fetch handshake and programmable wait states.
- Sits between the PC/fetch stage and the decoder of the datapath.
- Byte-addressed like the rest of the datapath: word index = fetch_addr >> 1 for 16-bit words.
- Adds a run-time program load port, so the program image is no longer hard-coded at reset.

Parameters:
- DATA_W, 16: instruction width in bits; must be 16 for byte-address shift of 1.
- DEPTH, 32: number of instruction words.
- ADDR_W, 16: byte-address width of fetch_addr and load_addr.
- WAIT_STATES, 1: extra cycles between fetch accept and response; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch request; accepted when fetch_req && fetch_ready.
- fetch_addr  in  ADDR_W  byte address of instruction; bit 0 ignored.
- fetch_ready  out  1  high when the block can accept a fetch (state IDLE).
- instr_valid  out  1  one-cycle pulse; instr_data is valid.
- instr_data  out  DATA_W  fetched instruction; held until the next response.
- fetch_err  out  1  out-of-range flag, qualified by instr_valid; present only with IMEM_BOUNDS_CHECK_EN.
- load_en  in  1  program-load write strobe.
- load_addr  in  ADDR_W  byte address of the load; bit 0 ignored.
- load_data  in  DATA_W  instruction word to write.

Behaviour:
- Reset (reset==0, asynchronous):
  - State goes to IDLE; wait counter cleared.
  - fetch_ready=1, instr_valid=0, instr_data=0, fetch_err=0.
  - Every memory word is cleared to 16'h0000 (NOP).
  - A pending fetch is dropped with no response.
  - Loads presented while reset is low are ignored.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - fetch_ready=1.
  - On accept, latch idx = fetch_addr[ADDR_W-1:1].
  - If WAIT_STATES==0, go to RESP; else go to WAIT with cnt=WAIT_STATES-1.
- WAIT:
  - fetch_ready=0.
  - If cnt==0, go to RESP; else decrement cnt.
  - fetch_req is ignored; the requester must hold the request or re-issue it after the response.
- Entry to RESP:
  - instr_data is registered from Memory[idx] on the edge entering RESP.
  - The read sees array contents before that edge (a same-edge load to idx does not affect the read).
- RESP:
  - instr_valid=1 for exactly one cycle, fetch_ready=0; then IDLE.
- Timing:
  - Latency: instr_valid rises WAIT_STATES+1 cycles after the accept edge.
  - Throughput: one fetch per WAIT_STATES+2 cycles.
- Load port:
  - Active in every state, synchronous write.
  - A load to word index >= DEPTH is ignored.
  - A load and a fetch accept in the same cycle are both performed.
- Address wrap (without the optional feature): idx >= DEPTH reads Memory[idx mod DEPTH].
- Misaligned fetch (bit 0 = 1): treated as the even address below it; no error raised.

Optional Feature:
- Macro: IMEM_BOUNDS_CHECK_EN.
- Defined:
  - fetch_err port exists.
  - A fetch with idx >= DEPTH returns instr_data=16'h0000 and fetch_err=1 with instr_valid.
  - In-range fetches return fetch_err=0.
- Undefined:
  - No fetch_err port.
  - idx wraps modulo DEPTH.
  - A load to idx >= DEPTH is still ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - NOP constant 16'h0000.
  - The byte-to-word shift constant (1).
- One sub-module, imem_array: DEPTH x DATA_W storage with async clear, synchronous write port and registered read port.
- The FSM and counter stay in the top level.

Test Plan:
- Reset clears state: pulse reset low mid-WAIT, then fetch 0x0004 -> no response for the dropped fetch; new response instr_data=16'h0000, and fetch_ready=1 immediately after reset.
- Load then fetch: load 0x0000<=16'h0120 and 0x0002<=16'h0121, then fetch 0x0002 (WAIT_STATES=1) -> instr_valid exactly 2 cycles after accept, instr_data=16'h0121.
- WAIT_STATES=0 and 3: fetch 0x0000 -> instr_valid at accept+1 and accept+4 respectively; fetch_ready low until the cycle after instr_valid.
- Same-edge load/read: load 0x0006<=16'hEFFF on the RESP-entry edge of a fetch of 0x0006 (old 16'h0564) -> instr_data=16'h0564; the next fetch of 0x0006 returns 16'hEFFF.
- Misaligned fetch: fetch 0x0003 after load 0x0002<=16'h09E2 -> instr_data=16'h09E2.
- Out of range (DEPTH=32):
  - Fetch 0x0042 (idx 33) after load 0x0002<=16'h0EF2.
  - Without the macro -> 16'h0EF2.
  - With IMEM_BOUNDS_CHECK_EN -> 16'h0000 and fetch_err=1.
